lamp_sequencer: RTL
===================

Name: lamp_sequencer

Overview:
- Drives the lamp panel: NUM_LAMPS lamp outputs, all from one sequencer, instead of tying each lamp to a constant.
- Holds a mode (off, all-on, chase, blink) and a step-rate divider, both set through a valid/ready config port.
- Sits between the board control logic and the lamp pins.
- Reset state reproduces the current panel behaviour: all lamps lit.

Parameters:
- NUM_LAMPS, 11, number of lamp outputs (minimum 2).
- DIV_W, 24, width of the step-rate divider.
- DEFAULT_DIV, 24'd49, divider value loaded at reset.
- PWM_W, 4, duty-cycle width (used only with LAMP_PWM_EN).

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  sequencer can accept a config.
- cfg_mode  in  2  0=OFF, 1=ALL_ON, 2=CHASE, 3=BLINK.
- cfg_div  in  DIV_W  step period minus 1, in clocks.
- lamps  out  NUM_LAMPS  lamp drive; bit i = lamp i+1; 1 = lit.
- step_pulse  out  1  one-cycle strobe on each pattern step.
- cfg_duty  in  PWM_W  duty select (present only with LAMP_PWM_EN).

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous, active-low, port `reset_n`.
- Reset values (reset_n=0 sampled at a rising edge):
  - state=S_ALL_ON, lamps=all ones, cfg_ready=1, step_pulse=0.
  - div_q=DEFAULT_DIV, cnt=0, pos=0, phase=1.
  - Reset mid-operation aborts any mode immediately, including S_LOAD.
- States: S_OFF, S_ALL_ON, S_CHASE, S_BLINK, S_LOAD.
- Handshake:
  - A config is accepted at an edge where cfg_valid && cfg_ready.
  - On accept, latch cfg_mode into mode_q, cfg_div into div_q and (with the macro) cfg_duty into duty_q; go to S_LOAD.
  - cfg_ready=0 only in S_LOAD.
  - cfg_valid held high is therefore accepted at most every 2nd cycle.
  - Payload is ignored while cfg_ready=0.
- S_LOAD (exactly 1 cycle):
  - lamps=0, step_pulse=0; clear cnt and pos, set phase=1.
  - Next state comes from mode_q.
- Prescaler:
  - In S_CHASE and S_BLINK only, cnt increments each cycle.
  - When cnt==div_q: tick=1 and cnt returns to 0.
  - div_q=0 gives a tick every cycle.
  - Period is div_q+1 cycles; the first tick comes div_q+1 cycles after entering the mode.
  - cnt holds at 0 in the other states.
- step_pulse is the registered tick: asserted in the same cycle the lamps show the new pattern.
- S_OFF: lamps=0.
- S_ALL_ON: lamps=all ones.
- S_CHASE:
  - lamps = 1<<pos.
  - On tick, pos+1; at pos==NUM_LAMPS-1, pos wraps to 0.
- S_BLINK:
  - lamps = {NUM_LAMPS{phase}}.
  - phase toggles on tick; it starts at 1, so the first displayed pattern is all lit.
- A new config accepted mid-step discards the partial count; no tick is issued for it.
- lamps and step_pulse are registered outputs; no combinational path from inputs to outputs.

Optional Feature:
- Macro: LAMP_PWM_EN.
- With the macro:
  - Port cfg_duty exists; duty_q resets to all ones.
  - A free-running pwm_cnt of width PWM_W runs in all states except S_LOAD and wraps.
  - lamps = pattern & {NUM_LAMPS{pwm_cnt <= duty_q}}, giving an on-fraction of (duty_q+1)/2^PWM_W.
  - duty all ones means fully on, identical to the build without the macro.
- Without the macro:
  - No cfg_duty port, no PWM counter.
  - lamps = pattern directly.

Decomposition:
- Package lamp_pkg holds:
  - mode_e enum (OFF, ALL_ON, CHASE, BLINK; 2 bits).
  - state_e enum.
  - Constants MODE_W=2 and DEFAULT_DIV.
- One natural sub-module: lamp_prescaler.
  - Signals: clear, enable, div, tick.
  - Instantiated once in lamp_sequencer.
- Pattern generation and the FSM stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release → lamps=11'h7FF, cfg_ready=1, step_pulse=0; remains so with no config.
- Chase: cfg_mode=2, cfg_div=2, one-cycle valid.
  - → one cycle with lamps=0 and cfg_ready=0.
  - → then lamps=11'h001, 11'h002, 11'h004, … each held for 3 cycles; step_pulse accompanies each change.
  - → after 11'h400 the pattern wraps to 11'h001 (33 cycles per lap).
- Blink: cfg_mode=3, cfg_div=0 → after the LOAD cycle, lamps alternate 11'h7FF / 11'h000 every cycle; step_pulse=1 continuously.
- Back-to-back configs: cfg_valid held high, mode toggling 2→1 each cycle.
  - → accepts occur only on alternate cycles; ignored payloads never reach the lamps.
  - → the final ALL_ON shows 11'h7FF.
- Reset mid-chase: pos=5, reset_n=0 for 1 cycle → next cycle lamps=11'h7FF, state ALL_ON, div_q=49.
- PWM (LAMP_PWM_EN defined): ALL_ON, cfg_duty=3 → each lamp lit 4 of every 16 cycles (pwm_cnt 0-3); cfg_duty=15 → always lit.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared types and constants for the lamp panel sequencer.
package lamp_pkg;

    localparam int unsigned MODE_W = 2;
    localparam logic [23:0] DEFAULT_DIV = 24'd49;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL_ON = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ALL_ON = 3'd1,
        S_CHASE  = 3'd2,
        S_BLINK  = 3'd3,
        S_LOAD   = 3'd4
    } state_e;

endpackage

// File: rtl/lamp_prescaler.sv
// Step-rate prescaler: pulses tick every div+1 enabled cycles; count is held at 0 when idle.
module lamp_prescaler
    import lamp_pkg::*;
#(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && !clear && (cnt == div);

    always_ff @(posedge clock) begin
        if (!reset_n || clear || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/lamp_sequencer.sv
// Lamp panel sequencer: off / all-on / chase / blink patterns with a configurable step rate.
// Define LAMP_PWM_EN to add the cfg_duty port and a per-panel PWM dimmer.
module lamp_sequencer
    import lamp_pkg::*;
#(
    parameter int unsigned      NUM_LAMPS   = 11,
    parameter int unsigned      DIV_W       = 24,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(lamp_pkg::DEFAULT_DIV),
    parameter int unsigned      PWM_W       = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [MODE_W-1:0]    cfg_mode,
    input  logic [DIV_W-1:0]     cfg_div,
`ifdef LAMP_PWM_EN
    input  logic [PWM_W-1:0]     cfg_duty,
`endif
    output logic [NUM_LAMPS-1:0] lamps,
    output logic                 step_pulse
);

    localparam int unsigned POS_W = $clog2(NUM_LAMPS);

    if (NUM_LAMPS < 2 || PWM_W == 0) begin : g_param_check
        $error("lamp_sequencer: NUM_LAMPS must be >= 2 and PWM_W >= 1");
    end

    state_e               state, state_n;
    mode_e                mode_q, mode_n;
    logic [DIV_W-1:0]     div_q, div_n;
    logic [POS_W-1:0]     pos, pos_n;
    logic                 phase, phase_n;
    logic [NUM_LAMPS-1:0] pattern_n, lamps_n;
    logic                 step_n, ready_n;
    logic                 accept, tick;

    assign accept = cfg_valid && cfg_ready;

    lamp_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept || (state == S_LOAD)),
        .enable  ((state == S_CHASE) || (state == S_BLINK)),
        .div     (div_q),
        .tick    (tick)
    );

`ifdef LAMP_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_n, pwm_cnt, pwm_n;

    always_comb begin
        duty_n = accept ? cfg_duty : duty_q;
        pwm_n  = (state == S_LOAD) ? pwm_cnt : pwm_cnt + PWM_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            duty_q  <= '1;
            pwm_cnt <= '0;
        end else begin
            duty_q  <= duty_n;
            pwm_cnt <= pwm_n;
        end
    end

    // Gate against the next-cycle counter so the mask lines up with the registered lamps.
    assign lamps_n = pattern_n & {NUM_LAMPS{pwm_n <= duty_n}};
`else
    assign lamps_n = pattern_n;
`endif

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n   = state;
        mode_n    = mode_q;
        div_n     = div_q;
        pos_n     = pos;
        phase_n   = phase;
        pattern_n = '0;
        step_n    = 1'b0;
        ready_n   = 1'b1;

        if (accept) begin
            state_n = S_LOAD;
            mode_n  = mode_e'(cfg_mode);
            div_n   = cfg_div;
        end else begin
            case (state)
                S_LOAD: begin
                    pos_n   = '0;
                    phase_n = 1'b1;
                    case (mode_q)
                        MODE_OFF:    state_n = S_OFF;
                        MODE_ALL_ON: state_n = S_ALL_ON;
                        MODE_CHASE:  state_n = S_CHASE;
                        default:     state_n = S_BLINK;
                    endcase
                end
                S_CHASE: begin
                    if (tick) begin
                        pos_n = (pos == POS_W'(NUM_LAMPS - 1)) ? '0 : pos + POS_W'(1);
                    end
                end
                S_BLINK: begin
                    if (tick) begin
                        phase_n = ~phase;
                    end
                end
                default: ;
            endcase
            step_n = tick;
        end

        case (state_n)
            S_ALL_ON: pattern_n = '1;
            S_CHASE:  pattern_n = NUM_LAMPS'(1) << pos_n;
            S_BLINK:  pattern_n = {NUM_LAMPS{phase_n}};
            default:  pattern_n = '0;
        endcase

        ready_n = (state_n != S_LOAD);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_ALL_ON;
            mode_q     <= MODE_ALL_ON;
            div_q      <= DEFAULT_DIV;
            pos        <= '0;
            phase      <= 1'b1;
            lamps      <= '1;
            step_pulse <= 1'b0;
            cfg_ready  <= 1'b1;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            div_q      <= div_n;
            pos        <= pos_n;
            phase      <= phase_n;
            lamps      <= lamps_n;
            step_pulse <= step_n;
            cfg_ready  <= ready_n;
        end
    end

endmodule
